ip_hdr_word_tracker: RTL and testbench
======================================

// Module: ip_hdr_word_tracker
// PURPOSE
//  Passive, zero-latency monitor on the 64-bit datapath, upstream of the IP checksum/TTL stage.
//  Skips module-header words (in_ctrl!=0), tracks the word position of each Ethernet/IPv4 packet
//  and drives the one-cycle word_* strobes that the checksum/TTL and lookup stages qualify in_data with.
//  Also flags non-IPv4 and truncated packets and keeps saturating statistics.
// PARAMETERS
//  DATA_WIDTH   64              datapath width; only 64 is supported
//  CTRL_WIDTH   DATA_WIDTH/8    control width
//  STAT_WIDTH   16              width of each statistics counter
// PORTS
//  clk                      in   1           single clock
//  reset_n                  in   1           asynchronous, active-low reset
//  in_data                  in   DATA_WIDTH  datapath word
//  in_ctrl                  in   CTRL_WIDTH  !=0: module header (before payload) or EOP marker (in payload)
//  in_wr                    in   1           word valid
//  word_MAC_DA_SA_HI        out  1           payload word 1 {DA[47:0], SA[47:32]}
//  word_ETH_IP_VER          out  1           word 2 {SA[31:0], ethertype, ver/ihl, tos}
//  word_IP_LEN_ID           out  1           word 3; asserted together with word_IP_FRAG_TTL_PROTO
//  word_IP_FRAG_TTL_PROTO   out  1           word 3
//  word_IP_CHECKSUM_SRC_HI  out  1           word 4; asserted together with word_IP_SRC_DST
//  word_IP_SRC_DST          out  1           word 4
//  word_IP_DST_LO           out  1           word 5
//  pkt_is_ipv4              out  1           registered; ethertype==16'h0800 of the current packet
//  pkt_short                out  1           one-cycle pulse: EOP arrived before word 5
//  num_pkts                 out  STAT_WIDTH  packets with a word 1, saturating
//  num_short_pkts           out  STAT_WIDTH  truncated packets, saturating
// BEHAVIOUR
//  - Reset (async assert, sync release): state=RESYNC; pkt_is_ipv4=0, pkt_short=0, counters=0.
//  - Strobes are combinational: (state==WORD_n) & in_wr. Same-cycle as in_data, zero latency.
//    At most one word position is active per cycle. All strobes are 0 when in_wr=0.
//  - FSM advances only on in_wr=1 cycles. With in_wr=0, the state holds:
//    RESYNC:    in_ctrl!=0 -> SKIP_HDRS; otherwise stay. Strobes are suppressed.
//               Recovers from a reset that landed mid-packet.
//    SKIP_HDRS: in_ctrl!=0 -> stay. in_ctrl==0 -> this word is word 1 (strobe it) -> WORD_2; num_pkts++.
//    WORD_2..WORD_5: strobe the position; next state WORD_n+1, with WORD_5 -> WAIT_EOP.
//    WAIT_EOP:  in_ctrl!=0 -> SKIP_HDRS.
//    EOP in any WORD_n state (in_ctrl!=0):
//      - the strobe for that word is still asserted;
//      - next state is SKIP_HDRS;
//      - if n<5: pkt_short=1 next cycle and num_short_pkts++;
//      - EOP on word 5 is legal, not short.
//    EOP on word 1: covered by the SKIP_HDRS rule, because in_ctrl!=0 there means a header word.
//  - pkt_is_ipv4 <= (in_data[31:16]==16'h0800) on word 2. It holds until the next word 2,
//    and is cleared when a new word 1 is seen.
//  - Counters saturate at all-ones. No wrap. A simultaneous saturation and increment is a no-op.
//  - Back-to-back packets: a packet's EOP word and the next packet's first header word
//    may be on consecutive in_wr cycles; no bubble is required.
//  - Word 5 of successive packets is always >=6 cycles apart, which satisfies the
//    checksum stage's 2-cycle carry fold.
//  - Reset mid-packet: return to RESYNC immediately. No strobe until the next in_ctrl!=0 word
//    has been consumed.
// STRUCTURE
//  - Shared package/defines:
//    - state encodings (RESYNC, SKIP_HDRS, WORD_1..WORD_5, WAIT_EOP);
//    - ETHERTYPE_IP = 16'h0800;
//    - the word-position numbering, shared with the checksum/TTL and lookup stages.
//  - One sub-module, sat_counter (WIDTH, inc, clear), instantiated twice for the statistics.
//  - FSM and strobe decode live in the top module.
// TESTING
//  1. 2 header words (ctrl=FF), 7 payload words, EOP ctrl=0x01
//     -> each strobe exactly once, in order, on payload words 1..5; num_pkts=1; pkt_short=0.
//  2. Payload of only 3 words, EOP on word 3
//     -> word_IP_LEN_ID & word_IP_FRAG_TTL_PROTO high on word 3; pkt_short pulses once;
//     num_short_pkts=1; next packet decodes normally.
//  3. Word 2 carries ethertype 0x0806 -> pkt_is_ipv4=0; with 0x0800 -> pkt_is_ipv4=1 from the cycle after word 2.
//  4. in_wr deasserted for 3 cycles between words 3 and 4
//     -> no strobes during the gap; word 4 strobes when in_wr returns.
//  5. reset_n pulsed low during word 3, followed by the remaining payload words and EOP, then a new packet
//     -> no strobes until EOP; the new packet decodes fully.
//  6. STAT_WIDTH=4, 17 packets -> num_pkts stops at 15.

Source files
------------

// File: rtl/ip_hdr_word_tracker_pkg.sv
// Shared definitions for the IP header word tracker: FSM states, ethertype and the
// word-position numbering used by the checksum/TTL and lookup stages.
package ip_hdr_word_tracker_pkg;

   localparam logic [15:0] ETHERTYPE_IP = 16'h0800;

   // Payload word positions (1-based, counted from the first non-header word)
   localparam int unsigned WORD_1 = 1;
   localparam int unsigned WORD_2 = 2;
   localparam int unsigned WORD_3 = 3;
   localparam int unsigned WORD_4 = 4;
   localparam int unsigned WORD_5 = 5;

   typedef enum logic [2:0] {
      StResync,
      StSkipHdrs,
      StWord1,
      StWord2,
      StWord3,
      StWord4,
      StWord5,
      StWaitEop
   } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             clear,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (inc && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/ip_hdr_word_tracker.sv
// Zero-latency word-position tracker for Ethernet/IPv4 packets on the 64-bit datapath.
// Drives same-cycle word strobes, flags non-IPv4 and truncated packets, keeps statistics.
module ip_hdr_word_tracker
   import ip_hdr_word_tracker_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned STAT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   input  logic                  in_wr,
   output logic                  word_MAC_DA_SA_HI,
   output logic                  word_ETH_IP_VER,
   output logic                  word_IP_LEN_ID,
   output logic                  word_IP_FRAG_TTL_PROTO,
   output logic                  word_IP_CHECKSUM_SRC_HI,
   output logic                  word_IP_SRC_DST,
   output logic                  word_IP_DST_LO,
   output logic                  pkt_is_ipv4,
   output logic                  pkt_short,
   output logic [STAT_WIDTH-1:0] num_pkts,
   output logic [STAT_WIDTH-1:0] num_short_pkts
);

   state_e     state_q, state_d;
   logic [5:1] strb;
   logic       ctrl_nz;
   logic       short_d;
   logic       pkt_short_q;
   logic       pkt_is_ipv4_q;
   logic       unused_data;

   assign ctrl_nz     = |in_ctrl;
   assign unused_data = ^{in_data[DATA_WIDTH-1:32], in_data[15:0]};

   // A non-zero ctrl inside WORD_2..WORD_4 is an early EOP: still strobe, then flag short.
   always_comb begin
      state_d = state_q;
      strb    = '0;
      short_d = 1'b0;
      if (in_wr) begin
         unique case (state_q)
            StResync: begin
               if (ctrl_nz) state_d = StSkipHdrs;
            end
            StSkipHdrs: begin
               if (!ctrl_nz) begin
                  strb[WORD_1] = 1'b1;
                  state_d      = StWord2;
               end
            end
            StWord2: begin
               strb[WORD_2] = 1'b1;
               state_d      = ctrl_nz ? StSkipHdrs : StWord3;
               short_d      = ctrl_nz;
            end
            StWord3: begin
               strb[WORD_3] = 1'b1;
               state_d      = ctrl_nz ? StSkipHdrs : StWord4;
               short_d      = ctrl_nz;
            end
            StWord4: begin
               strb[WORD_4] = 1'b1;
               state_d      = ctrl_nz ? StSkipHdrs : StWord5;
               short_d      = ctrl_nz;
            end
            StWord5: begin
               strb[WORD_5] = 1'b1;
               state_d      = ctrl_nz ? StSkipHdrs : StWaitEop;
            end
            StWaitEop: begin
               if (ctrl_nz) state_d = StSkipHdrs;
            end
            default: state_d = StResync;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StResync;
         pkt_short_q   <= 1'b0;
         pkt_is_ipv4_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pkt_short_q <= short_d;
         if (strb[WORD_1]) begin
            pkt_is_ipv4_q <= 1'b0;
         end else if (strb[WORD_2]) begin
            pkt_is_ipv4_q <= (in_data[31:16] == ETHERTYPE_IP);
         end
      end
   end

   sat_counter #(
      .WIDTH (STAT_WIDTH)
   ) u_pkt_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (strb[WORD_1]),
      .clear   (1'b0),
      .count   (num_pkts)
   );

   sat_counter #(
      .WIDTH (STAT_WIDTH)
   ) u_short_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (short_d),
      .clear   (1'b0),
      .count   (num_short_pkts)
   );

   assign word_MAC_DA_SA_HI       = strb[WORD_1];
   assign word_ETH_IP_VER         = strb[WORD_2];
   assign word_IP_LEN_ID          = strb[WORD_3];
   assign word_IP_FRAG_TTL_PROTO  = strb[WORD_3];
   assign word_IP_CHECKSUM_SRC_HI = strb[WORD_4];
   assign word_IP_SRC_DST         = strb[WORD_4];
   assign word_IP_DST_LO          = strb[WORD_5];
   assign pkt_is_ipv4             = pkt_is_ipv4_q;
   assign pkt_short               = pkt_short_q;

endmodule

// File: tb/tb_ip_hdr_word_tracker.sv
// Directed bench for ip_hdr_word_tracker: strobe sequencing, short packets, ethertype
// detection, in_wr gaps, mid-packet reset and counter saturation (STAT_WIDTH=4).
module tb_ip_hdr_word_tracker;

   localparam int unsigned SW = 4;

   localparam logic [6:0] S0 = 7'b000_0000;
   localparam logic [6:0] S1 = 7'b100_0000;
   localparam logic [6:0] S2 = 7'b010_0000;
   localparam logic [6:0] S3 = 7'b001_1000;
   localparam logic [6:0] S4 = 7'b000_0110;
   localparam logic [6:0] S5 = 7'b000_0001;

   localparam logic [63:0] D_IP  = 64'h0011_2233_0800_4500;
   localparam logic [63:0] D_ARP = 64'h4455_6677_0806_0001;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [63:0]   in_data = '0;
   logic [7:0]    in_ctrl = '0;
   logic          in_wr = 1'b0;
   logic          word_MAC_DA_SA_HI, word_ETH_IP_VER, word_IP_LEN_ID, word_IP_FRAG_TTL_PROTO;
   logic          word_IP_CHECKSUM_SRC_HI, word_IP_SRC_DST, word_IP_DST_LO;
   logic          pkt_is_ipv4, pkt_short;
   logic [SW-1:0] num_pkts, num_short_pkts;
   logic [6:0]    strb;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [6:0] obs_strb;
   logic       obs_short;
   logic       obs_ipv4;

   ip_hdr_word_tracker #(
      .DATA_WIDTH (64),
      .CTRL_WIDTH (8),
      .STAT_WIDTH (SW)
   ) dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .in_data                 (in_data),
      .in_ctrl                 (in_ctrl),
      .in_wr                   (in_wr),
      .word_MAC_DA_SA_HI       (word_MAC_DA_SA_HI),
      .word_ETH_IP_VER         (word_ETH_IP_VER),
      .word_IP_LEN_ID          (word_IP_LEN_ID),
      .word_IP_FRAG_TTL_PROTO  (word_IP_FRAG_TTL_PROTO),
      .word_IP_CHECKSUM_SRC_HI (word_IP_CHECKSUM_SRC_HI),
      .word_IP_SRC_DST         (word_IP_SRC_DST),
      .word_IP_DST_LO          (word_IP_DST_LO),
      .pkt_is_ipv4             (pkt_is_ipv4),
      .pkt_short               (pkt_short),
      .num_pkts                (num_pkts),
      .num_short_pkts          (num_short_pkts)
   );

   assign strb = {word_MAC_DA_SA_HI, word_ETH_IP_VER, word_IP_LEN_ID, word_IP_FRAG_TTL_PROTO,
                  word_IP_CHECKSUM_SRC_HI, word_IP_SRC_DST, word_IP_DST_LO};

   always #5 clk = ~clk;

   // Drive one beat at the falling edge and capture outputs before the next rising edge.
   task automatic beat(input logic wr, input logic [7:0] ctrl, input logic [63:0] data);
      @(negedge clk);
      in_wr   = wr;
      in_ctrl = ctrl;
      in_data = data;
      #1;
      obs_strb  = strb;
      obs_short = pkt_short;
      obs_ipv4  = pkt_is_ipv4;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      in_wr   = 1'b1;
      in_ctrl = 8'h00;
      in_data = D_IP;
      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if ({strb, pkt_short, pkt_is_ipv4, num_pkts, num_short_pkts} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got strb=%b short=%b ipv4=%b pkts=%0d short_pkts=%0d want all 0",
                  strb, pkt_short, pkt_is_ipv4, num_pkts, num_short_pkts);
      end
      reset_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         beat(1'b1, 8'h00, D_IP);
         n_cmp++;
         if (obs_strb !== S0) begin
            n_fail++;
            $display("FAIL resync_suppress beat %0d: got %b want %b", i, obs_strb, S0);
         end
      end
   endtask

   task automatic test_full_packet();
      logic [7:0] c [9] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
      logic [6:0] e [9] = '{S0, S0, S1, S2, S3, S4, S5, S0, S0};
      for (int i = 0; i < 9; i++) begin
         beat(1'b1, c[i], D_IP);
         n_cmp++;
         if (obs_strb !== e[i]) begin
            n_fail++;
            $display("FAIL full_strb beat %0d: got %b want %b", i, obs_strb, e[i]);
         end
         n_cmp++;
         if (obs_short !== 1'b0) begin
            n_fail++;
            $display("FAIL full_short beat %0d: got %b want 0", i, obs_short);
         end
         if (i == 4) begin
            n_cmp++;
            if (obs_ipv4 !== 1'b1) begin
               n_fail++;
               $display("FAIL full_ipv4: got %b want 1", obs_ipv4);
            end
         end
      end
      n_cmp++;
      if (num_pkts !== SW'(1)) begin
         n_fail++;
         $display("FAIL full_num_pkts: got %0d want 1", num_pkts);
      end
   endtask

   task automatic test_short_packet();
      logic [7:0] c [12] = '{8'hFF, 8'h00, 8'h00, 8'h01, 8'hFF, 8'h00,
                             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
      logic [6:0] e [12] = '{S0, S1, S2, S3, S0, S1, S2, S3, S4, S5, S0, S0};
      logic       s [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 12; i++) begin
         beat(1'b1, c[i], D_IP);
         n_cmp++;
         if (obs_strb !== e[i]) begin
            n_fail++;
            $display("FAIL short_strb beat %0d: got %b want %b", i, obs_strb, e[i]);
         end
         n_cmp++;
         if (obs_short !== s[i]) begin
            n_fail++;
            $display("FAIL short_pulse beat %0d: got %b want %b", i, obs_short, s[i]);
         end
      end
      n_cmp++;
      if (num_short_pkts !== SW'(1)) begin
         n_fail++;
         $display("FAIL short_count: got %0d want 1", num_short_pkts);
      end
      n_cmp++;
      if (num_pkts !== SW'(3)) begin
         n_fail++;
         $display("FAIL short_num_pkts: got %0d want 3", num_pkts);
      end
   endtask

   task automatic test_ethertype();
      logic [7:0]  c [14] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                              8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
      logic        e [14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [63:0] d;
      for (int i = 0; i < 14; i++) begin
         d = (i == 2) ? D_ARP : (i == 9) ? D_IP : 64'h0;
         beat(1'b1, c[i], d);
         n_cmp++;
         if (obs_ipv4 !== e[i]) begin
            n_fail++;
            $display("FAIL ethertype_ipv4 beat %0d: got %b want %b", i, obs_ipv4, e[i]);
         end
      end
   endtask

   task automatic test_wr_gap();
      logic       w [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                             1'b1, 1'b1, 1'b1, 1'b1};
      logic [7:0] c [11] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00,
                             8'h00, 8'h00, 8'h00, 8'h01};
      logic [6:0] e [11] = '{S0, S1, S2, S3, S0, S0, S0, S4, S5, S0, S0};
      for (int i = 0; i < 11; i++) begin
         beat(w[i], c[i], D_IP);
         n_cmp++;
         if (obs_strb !== e[i]) begin
            n_fail++;
            $display("FAIL gap_strb beat %0d: got %b want %b", i, obs_strb, e[i]);
         end
      end
      n_cmp++;
      if (num_pkts !== SW'(6)) begin
         n_fail++;
         $display("FAIL gap_num_pkts: got %0d want 6", num_pkts);
      end
   endtask

   task automatic test_mid_reset();
      logic [7:0] c [12] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hFF, 8'h00,
                             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
      logic [6:0] e [12] = '{S0, S0, S0, S0, S0, S1, S2, S3, S4, S5, S0, S0};
      beat(1'b1, 8'hFF, D_IP);
      beat(1'b1, 8'h00, D_IP);
      beat(1'b1, 8'h00, D_IP);
      beat(1'b1, 8'h00, D_IP);
      n_cmp++;
      if (obs_strb !== S3) begin
         n_fail++;
         $display("FAIL midrst_word3: got %b want %b", obs_strb, S3);
      end
      #1 reset_n = 1'b0;
      #1 reset_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         beat(1'b1, c[i], D_IP);
         n_cmp++;
         if (obs_strb !== e[i]) begin
            n_fail++;
            $display("FAIL midrst_strb beat %0d: got %b want %b", i, obs_strb, e[i]);
         end
         if (i == 0) begin
            n_cmp++;
            if ({num_pkts, num_short_pkts} !== '0) begin
               n_fail++;
               $display("FAIL midrst_counters: got pkts=%0d short=%0d want 0/0",
                        num_pkts, num_short_pkts);
            end
         end
      end
      n_cmp++;
      if (num_pkts !== SW'(1)) begin
         n_fail++;
         $display("FAIL midrst_num_pkts: got %0d want 1", num_pkts);
      end
   endtask

   task automatic test_back_to_back_saturation();
      logic [SW-1:0] exp_cnt;
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int p = 1; p <= 17; p++) begin
         beat(1'b1, 8'hFF, D_IP);
         beat(1'b1, 8'h00, D_IP);
         n_cmp++;
         if (obs_strb !== S1 || obs_short !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_word1 pkt %0d: got strb=%b short=%b want %b/0",
                     p, obs_strb, obs_short, S1);
         end
         beat(1'b1, 8'h00, D_IP);
         exp_cnt = (p > 15) ? SW'(15) : SW'(p);
         n_cmp++;
         if (num_pkts !== exp_cnt) begin
            n_fail++;
            $display("FAIL b2b_num_pkts pkt %0d: got %0d want %0d", p, num_pkts, exp_cnt);
         end
         beat(1'b1, 8'h00, D_IP);
         beat(1'b1, 8'h00, D_IP);
         beat(1'b1, 8'h01, D_IP);
         n_cmp++;
         if (obs_strb !== S5) begin
            n_fail++;
            $display("FAIL b2b_eop_word5 pkt %0d: got %b want %b", p, obs_strb, S5);
         end
      end
      beat(1'b1, 8'hFF, D_IP);
      n_cmp++;
      if (obs_short !== 1'b0 || num_short_pkts !== '0 || num_pkts !== SW'(15)) begin
         n_fail++;
         $display("FAIL b2b_final: got short=%b short_pkts=%0d pkts=%0d want 0/0/15",
                  obs_short, num_short_pkts, num_pkts);
      end
   endtask

   initial begin
      test_reset();
      test_full_packet();
      test_short_packet();
      test_ethertype();
      test_wr_gap();
      test_mid_reset();
      test_back_to_back_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
